// File: rtl/check_mon_pkg.sv
// Shared types and constants for the check-bus monitor and its serializer.
package check_mon_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } ser_state_e;

    localparam int unsigned DefWidth = 40;
    localparam int unsigned DefCntW  = 16;

    // Wide enough to count every beat of a dump, including the optional parity beat.
    function automatic int unsigned beat_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned DefBeatCntW = beat_cnt_w(DefWidth);

endpackage

// File: rtl/check_mon_ser.sv
// Serial readout of a sticky snapshot, MSB first, with valid/ready handshake.
// Define CHECK_MON_PARITY_EN to append one even-parity beat after the data bits.
module check_mon_ser
    import check_mon_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] snap_i,
    input  logic             dump_req_i,
    input  logic             ser_ready_i,
    output logic             ser_valid_o,
    output logic             ser_bit_o,
    output logic             ser_last_o,
    output logic             busy_o
);

    localparam int unsigned BeatW = beat_cnt_w(WIDTH);
`ifdef CHECK_MON_PARITY_EN
    localparam int unsigned ShiftW = WIDTH + 1;
`else
    localparam int unsigned ShiftW = WIDTH;
`endif
    localparam logic [BeatW-1:0] LastBeat = BeatW'(ShiftW - 1);

    ser_state_e        state_q, state_d;
    logic [ShiftW-1:0] shift_q, shift_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [ShiftW-1:0] load_val;
    logic              in_shift;

    // Parity rides in the LSB so the MSB-first shifter emits it after the data.
`ifdef CHECK_MON_PARITY_EN
    assign load_val = {snap_i, ^snap_i};
`else
    assign load_val = snap_i;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        beat_d  = beat_q;
        case (state_q)
            StIdle: begin
                if (dump_req_i) begin
                    shift_d = load_val;
                    beat_d  = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (ser_ready_i) begin
                    shift_d = shift_q << 1;
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_shift    = (state_q == StShift);
    assign ser_valid_o = in_shift;
    assign busy_o      = in_shift;
    assign ser_bit_o   = in_shift & shift_q[ShiftW-1];
    assign ser_last_o  = in_shift && (beat_q == LastBeat);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            shift_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: rtl/check_bus_monitor.sv
// Accumulates failing check-bus samples (sticky bits, saturating count, flag) and
// serializes the sticky bits on request. CHECK_MON_PARITY_EN adds a parity beat.
module check_bus_monitor
    import check_mon_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] chk_in,
    input  logic             chk_valid,
    input  logic             clear,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] sticky,
    input  logic             dump_req,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             busy
);

    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             fail;

    assign fail = chk_valid && (chk_in != '0);

    // Clear outranks a coincident failing sample; the sample is dropped.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        flag_d   = flag_q;
        if (clear) begin
            sticky_d = '0;
            cnt_d    = '0;
            flag_d   = 1'b0;
        end else if (fail) begin
            sticky_d = sticky_q | chk_in;
            flag_d   = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
        end
    end

    assign sticky   = sticky_q;
    assign err_cnt  = cnt_q;
    assign err_flag = flag_q;

    // Snapshot uses the registered sticky, so a same-cycle failing sample is excluded.
    check_mon_ser #(
        .WIDTH(WIDTH)
    ) u_ser (
        .clk_i      (clk),
        .rst_i      (rst),
        .snap_i     (sticky_q),
        .dump_req_i (dump_req),
        .ser_ready_i(ser_ready),
        .ser_valid_o(ser_valid),
        .ser_bit_o  (ser_bit),
        .ser_last_o (ser_last),
        .busy_o     (busy)
    );

endmodule
